// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   - sched_state_e : scheduler FSM states
//   - UART_DATA_W   : byte width carried to the transmitter
//   - baud constants: 100 MHz clock, 9600 baud, 16x oversampling
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  localparam int unsigned CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned BAUD_RATE   = 9600;
  localparam int unsigned OVERSAMPLE  = 16;
  // Clock cycles per oversampling tick.
  localparam int unsigned BAUD_DIV    = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);

  typedef enum logic [1:0] {
    IDLE_S,
    ISSUE_S,
    WAIT_DONE_S,
    GAP_S
  } sched_state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin selector.
//   req   : request vector
//   ptr   : index of the previous owner; search starts at ptr+1 and wraps
//   sel   : one-hot winner (zero when nothing requests)
//   found : at least one request was present
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NUM_REQ-1:0] sel,
  output logic               found
);

  always_comb begin
    int unsigned j;
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        sel[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters.
// Round-robin arbitration with burst locking (up to MAX_BURST bytes per grant),
// an inter-frame gap of GAP_CYCLES after every tx_done, and a watchdog that
// abandons a frame if tx_done does not arrive within TIMEOUT_CYCLES.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/data/last : per-requester byte, data packed 8 bits per requester
//   req_ready           : acceptance strobe (only in ISSUE, only for the owner)
//   grant, busy         : one-hot owner, scheduler not idle
//   tx_start, tx_data   : transmitter start pulse and byte
//   tx_done             : transmitter completion pulse
//   err_timeout         : one-cycle watchdog expiry pulse
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_done,
  output logic                           err_timeout
);

  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam int unsigned BurstW = $clog2(MAX_BURST) + 1;
  localparam int unsigned GapW   = $clog2(GAP_CYCLES) + 1;
  localparam int unsigned WdW    = $clog2(TIMEOUT_CYCLES) + 1;

  localparam int unsigned GapLastInt = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);
  localparam logic [GapW-1:0]   GapLast   = GapW'(GapLastInt);
  localparam logic [WdW-1:0]    WdLast    = WdW'(TIMEOUT_CYCLES - 1);

  sched_state_e             state_q;
  logic [NUM_REQ-1:0]       grant_q;
  logic [IdxW-1:0]          owner_q;
  logic [IdxW-1:0]          last_owner_q;
  logic [BurstW-1:0]        byte_cnt_q;
  logic [GapW-1:0]          gap_q;
  logic [WdW-1:0]           wd_q;
  logic                     end_flag_q;
  logic                     busy_q;
  logic                     tx_start_q;
  logic [UART_DATA_W-1:0]   tx_data_q;
  logic                     err_timeout_q;

  logic [NUM_REQ-1:0]       pick_sel;
  logic                     pick_found;
  logic [IdxW-1:0]          pick_idx;
  logic                     own_valid;
  logic                     own_last;
  logic [UART_DATA_W-1:0]   own_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (last_owner_q),
    .sel   (pick_sel),
    .found (pick_found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_sel[i]) pick_idx = IdxW'(i);
    end
  end

  // Current owner's request fields.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IdxW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*UART_DATA_W +: UART_DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE_S;
      grant_q       <= '0;
      owner_q       <= '0;
      last_owner_q  <= IdxW'(NUM_REQ - 1);
      byte_cnt_q    <= '0;
      gap_q         <= '0;
      wd_q          <= '0;
      end_flag_q    <= 1'b0;
      busy_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tx_start_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      unique case (state_q)
        IDLE_S: begin
          if (pick_found) begin
            grant_q    <= pick_sel;
            owner_q    <= pick_idx;
            byte_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ISSUE_S;
          end
        end
        ISSUE_S: begin
          if (own_valid) begin
            tx_data_q  <= own_data;
            tx_start_q <= 1'b1;
            if (byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + 1'b1;
            end_flag_q <= own_last | (byte_cnt_q == BurstLast);
            wd_q       <= '0;
            state_q    <= WAIT_DONE_S;
          end else begin
            // Owner went away mid-burst: give the channel up.
            last_owner_q <= owner_q;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            state_q      <= IDLE_S;
          end
        end
        WAIT_DONE_S: begin
          // tx_done takes priority over a same-cycle watchdog expiry.
          if (tx_done) begin
            if (GAP_CYCLES == 0) begin
              if (end_flag_q) begin
                last_owner_q <= owner_q;
                grant_q      <= '0;
                busy_q       <= 1'b0;
                state_q      <= IDLE_S;
              end else begin
                state_q <= ISSUE_S;
              end
            end else begin
              gap_q   <= '0;
              state_q <= GAP_S;
            end
          end else if (wd_q == WdLast) begin
            err_timeout_q <= 1'b1;
            last_owner_q  <= owner_q;
            grant_q       <= '0;
            busy_q        <= 1'b0;
            state_q       <= IDLE_S;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        GAP_S: begin
          if (gap_q == GapLast) begin
            if (end_flag_q) begin
              last_owner_q <= owner_q;
              grant_q      <= '0;
              busy_q       <= 1'b0;
              state_q      <= IDLE_S;
            end else begin
              state_q <= ISSUE_S;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  assign req_ready   = (state_q == ISSUE_S) ? (grant_q & req_valid) : '0;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  uart_tx_scheduler #(
    .NUM_REQ        (4),
    .MAX_BURST      (3),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .busy        (busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]       = v;
    req_data[i*8 +: 8] = d;
    req_last[i]        = l;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " grant"}, 32'(grant), 32'd0);
    check({tag, " ready"}, 32'(req_ready), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " tx_start"}, 32'(tx_start), 32'd0);
    check({tag, " tx_data"}, 32'(tx_data), 32'd0);
    check({tag, " err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  // Bounded wait for the next tx_start; leaves time at that falling edge.
  task automatic wait_start(input string tag, input logic [7:0] exp_data,
                            input logic [3:0] exp_grant);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = tx_start;
    end
    check({tag, " start"}, 32'(seen), 32'd1);
    check({tag, " data"}, 32'(tx_data), 32'(exp_data));
    check({tag, " grant"}, 32'(grant), 32'(exp_grant));
  endtask

  // Transmitter model: tx_done 20 cycles after the tx_start cycle.
  task automatic finish_byte();
    repeat (20) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_done   = 1'b0;
    repeat (3) tick();
    check_reset_vals("por");
    reset = 1'b0;

    // Single byte: exact latency and gap length.
    tick();
    set_req(0, 1'b1, 8'hA5, 1'b1);
    tick();
    check("single grant", 32'(grant), 32'd1);
    check("single busy", 32'(busy), 32'd1);
    check("single ready", 32'(req_ready), 32'd1);
    check("single no early start", 32'(tx_start), 32'd0);
    tick();
    check("single tx_start", 32'(tx_start), 32'd1);
    check("single tx_data", 32'(tx_data), 32'hA5);
    check("single ready low", 32'(req_ready), 32'd0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    finish_byte();
    repeat (3) tick();
    check("single gap busy", 32'(busy), 32'd1);
    check("single gap grant", 32'(grant), 32'd1);
    tick();
    check("single idle busy", 32'(busy), 32'd0);
    check("single idle grant", 32'(grant), 32'd0);

    // Round-robin from a fresh pointer.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 8'(8'hC0 + k), 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_start($sformatf("rr%0d", k), 8'(8'hC0 + k), 4'(1 << k));
      set_req(k, 1'b0, 8'h00, 1'b0);
      finish_byte();
    end
    set_req(0, 1'b1, 8'hD0, 1'b1);
    set_req(2, 1'b1, 8'hD2, 1'b1);
    wait_start("rr0b", 8'hD0, 4'b0001);
    set_req(0, 1'b0, 8'h00, 1'b0);
    finish_byte();
    wait_start("rr2b", 8'hD2, 4'b0100);
    set_req(2, 1'b0, 8'h00, 1'b0);
    finish_byte();

    // Burst cap: req1 loses the grant after 3 bytes, req3 gets a turn.
    set_req(1, 1'b1, 8'h10, 1'b0);
    wait_start("burst10", 8'h10, 4'b0010);
    set_req(3, 1'b1, 8'h33, 1'b1);
    set_req(1, 1'b1, 8'h11, 1'b0);
    finish_byte();
    wait_start("burst11", 8'h11, 4'b0010);
    set_req(1, 1'b1, 8'h12, 1'b0);
    finish_byte();
    wait_start("burst12", 8'h12, 4'b0010);
    set_req(1, 1'b1, 8'h13, 1'b0);
    finish_byte();
    wait_start("burst33", 8'h33, 4'b1000);
    set_req(3, 1'b0, 8'h00, 1'b0);
    finish_byte();
    wait_start("burst13", 8'h13, 4'b0010);
    set_req(1, 1'b1, 8'h14, 1'b1);
    finish_byte();
    wait_start("burst14", 8'h14, 4'b0010);
    set_req(1, 1'b0, 8'h00, 1'b0);
    finish_byte();

    // Abandoned burst: req2 drops valid after its first byte completes.
    set_req(2, 1'b1, 8'h20, 1'b0);
    wait_start("aband20", 8'h20, 4'b0100);
    set_req(0, 1'b1, 8'h0A, 1'b1);
    finish_byte();
    set_req(2, 1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    check("aband gap grant", 32'(grant), 32'b0100);
    tick();
    check("aband issue grant", 32'(grant), 32'b0100);
    check("aband issue ready", 32'(req_ready), 32'd0);
    check("aband issue no start", 32'(tx_start), 32'd0);
    tick();
    check("aband released grant", 32'(grant), 32'd0);
    check("aband released busy", 32'(busy), 32'd0);
    check("aband released no start", 32'(tx_start), 32'd0);
    tick();
    check("aband next grant", 32'(grant), 32'b0001);
    tick();
    check("aband next start", 32'(tx_start), 32'd1);
    check("aband next data", 32'(tx_data), 32'h0A);
    set_req(0, 1'b0, 8'h00, 1'b0);
    finish_byte();
    repeat (5) tick();

    // Watchdog expiry: no tx_done for the frame.
    set_req(3, 1'b1, 8'h3C, 1'b1);
    tick();
    check("wd grant", 32'(grant), 32'b1000);
    tick();
    check("wd start", 32'(tx_start), 32'd1);
    set_req(3, 1'b0, 8'h00, 1'b0);
    repeat (63) tick();
    check("wd not yet", 32'(err_timeout), 32'd0);
    check("wd still busy", 32'(busy), 32'd1);
    tick();
    check("wd pulse", 32'(err_timeout), 32'd1);
    check("wd grant released", 32'(grant), 32'd0);
    check("wd busy low", 32'(busy), 32'd0);
    tick();
    check("wd pulse one cycle", 32'(err_timeout), 32'd0);

    // tx_done on the last watchdog cycle beats the timeout.
    set_req(3, 1'b1, 8'h3D, 1'b1);
    tick();
    tick();
    check("wdlate start", 32'(tx_start), 32'd1);
    check("wdlate data", 32'(tx_data), 32'h3D);
    set_req(3, 1'b0, 8'h00, 1'b0);
    repeat (63) tick();
    tx_done = 1'b1;
    check("wdlate no err", 32'(err_timeout), 32'd0);
    tick();
    tx_done = 1'b0;
    check("wdlate no err after", 32'(err_timeout), 32'd0);
    check("wdlate in gap", 32'(busy), 32'd1);
    repeat (4) tick();
    check("wdlate idle", 32'(busy), 32'd0);
    check("wdlate no err end", 32'(err_timeout), 32'd0);

    // Reset while waiting for tx_done.
    set_req(1, 1'b1, 8'h50, 1'b0);
    tick();
    tick();
    check("rst start", 32'(tx_start), 32'd1);
    check("rst grant", 32'(grant), 32'b0010);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0;
    set_req(0, 1'b1, 8'h60, 1'b1);
    set_req(2, 1'b1, 8'h62, 1'b1);
    tick();
    check("postrst no start", 32'(tx_start), 32'd0);
    check("postrst grant", 32'(grant), 32'b0001);
    tick();
    check("postrst start", 32'(tx_start), 32'd1);
    check("postrst data", 32'(tx_data), 32'h60);
    req_valid = '0;
    finish_byte();
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
